// File: rtl/outr_uart_pkg.sv
// Shared types and constants for the OUTR serial output stage.
package outr_uart_pkg;

    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned BYTES_PER_WORD = 2;
    localparam int unsigned BIT_IDX_W      = $clog2(DATA_BITS);
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/outr_uart_tx_bit_timer.sv
// Bit-time counter: wraps every CLKS_PER_BIT cycles, restartable on state entry.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term   = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    // Terminal count depends on the counter only, so the FSM can use it freely.
    assign o_tick_c = w_term;

    // Count 0..CLKS_PER_BIT-1, back to 0 on terminal count or restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_restart || w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/outr_uart_tx.sv
// OUTR word to 8N1 UART, two bytes per word, low byte first, one-word holding buffer.
module outr_uart_tx
    import outr_uart_pkg::*;
#(
    parameter int unsigned Bits         = 16,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [Bits-1:0] outr_data,
    input  logic            outr_load,
    output logic            fgo,
    output logic            tx,
    output logic            busy,
    output logic            overrun
);

    uart_state_t           r_state;
    uart_state_t           w_next_state;
    logic [Bits-1:0]       r_buf;
    logic [Bits-1:0]       r_shift;
    logic [BIT_IDX_W-1:0]  r_bit;
    logic [BIT_IDX_W-1:0]  w_bit_next;
    logic [BYTE_IDX_W-1:0] r_byte;
    logic [BYTE_IDX_W-1:0] w_byte_next;
    logic                  w_xfer;
    logic                  w_tick;
    logic                  w_restart;
    logic                  w_tx_next;
    logic                  w_busy_next;
    logic                  r_fgo;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_overrun;

    // Timer is held at zero while idle and restarted on every state entry.
    assign w_restart = (r_state == ST_IDLE) || (w_next_state != r_state) || w_xfer;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .i_restart(w_restart),
        .o_tick_c (w_tick)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, bit/byte position and buffer-to-shifter transfer decision.
    always_comb begin
        w_next_state = r_state;
        w_bit_next   = r_bit;
        w_byte_next  = r_byte;
        w_xfer       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_fgo) begin
                    w_xfer       = 1'b1;
                    w_next_state = ST_START;
                    w_byte_next  = '0;
                    w_bit_next   = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_next_state = ST_DATA;
                    w_bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit == BIT_IDX_W'(DATA_BITS - 1)) begin
                        w_next_state = ST_STOP;
                    end else begin
                        w_bit_next = r_bit + BIT_IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_byte != BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
                        w_next_state = ST_START;
                        w_byte_next  = r_byte + BYTE_IDX_W'(1);
                        w_bit_next   = '0;
                    end else if (!r_fgo) begin
                        // Back-to-back word: no idle cycle between frames.
                        w_xfer       = 1'b1;
                        w_next_state = ST_START;
                        w_byte_next  = '0;
                        w_bit_next   = '0;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Line level and busy for the state being entered, registered below.
    always_comb begin
        w_busy_next = (w_next_state != ST_IDLE);
        w_tx_next   = 1'b1;
        case (w_next_state)
            ST_IDLE:  w_tx_next = 1'b1;
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = r_shift[{w_byte_next, w_bit_next}];
            ST_STOP:  w_tx_next = 1'b1;
            default:  w_tx_next = 1'b1;
        endcase
    end

    // Buffer, shifter, position counters, flags and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf     <= '0;
            r_shift   <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_fgo     <= 1'b1;
            r_overrun <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_bit  <= w_bit_next;
            r_byte <= w_byte_next;
            r_tx   <= w_tx_next;
            r_busy <= w_busy_next;
            if (w_xfer) begin
                r_shift <= r_buf;
                r_fgo   <= 1'b1;
            end
            // A load needs an empty buffer as seen before this edge.
            if (outr_load) begin
                if (r_fgo) begin
                    r_buf <= outr_data;
                    r_fgo <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign fgo     = r_fgo;
    assign tx      = r_tx;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_outr_uart_tx.sv
// Self-checking bench for outr_uart_tx against a frame-position reference model.
module tb_outr_uart_tx;

    localparam int N     = 4;
    localparam int FRAME = 20 * N;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] outr_data = 16'h0000;
    logic        outr_load = 1'b0;
    logic        fgo;
    logic        tx;
    logic        busy;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic cmp_en = 1'b0;

    typedef struct {
        logic        active;
        int          t;
        logic [15:0] word;
        logic        buf_full;
        logic [15:0] buff;
        logic        ovr;
    } model_t;

    model_t m;

    outr_uart_tx #(
        .Bits(16),
        .CLKS_PER_BIT(N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .outr_data(outr_data),
        .outr_load(outr_load),
        .fgo      (fgo),
        .tx       (tx),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Line level at frame bit position pos (0..19) of word w.
    function automatic logic frame_bit(input logic [15:0] w, input int pos);
        if (pos == 0 || pos == 10) return 1'b0;
        if (pos == 9 || pos == 19) return 1'b1;
        if (pos < 9) return w[pos - 1];
        return w[pos - 3];
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.active = 1'b0; r.t = 0; r.word = 16'h0;
        r.buf_full = 1'b0; r.buff = 16'h0; r.ovr = 1'b0;
        return r;
    endfunction

    // One clock edge of the reference: accept/drop load, start/advance/end frame.
    function automatic model_t model_step(input model_t cur, input logic ld, input logic [15:0] d);
        model_t nx;
        logic done;
        logic xfer;
        nx   = cur;
        done = cur.active && (cur.t == FRAME - 1);
        xfer = cur.buf_full && (!cur.active || done);
        if (ld) begin
            if (!cur.buf_full) begin
                nx.buf_full = 1'b1;
                nx.buff     = d;
            end else begin
                nx.ovr = 1'b1;
            end
        end
        if (xfer) begin
            nx.word = cur.buff; nx.t = 0; nx.active = 1'b1; nx.buf_full = 1'b0;
        end else if (done) begin
            nx.active = 1'b0; nx.t = 0;
        end else if (cur.active) begin
            nx.t = cur.t + 1;
        end
        return nx;
    endfunction

    function automatic logic model_tx(input model_t s);
        return s.active ? frame_bit(s.word, s.t / N) : 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m, outr_load, outr_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Every cycle the model is valid, all four outputs must follow it.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("model_tx",      {31'd0, tx},      {31'd0, model_tx(m)});
            check("model_busy",    {31'd0, busy},    {31'd0, m.active});
            check("model_fgo",     {31'd0, fgo},     {31'd0, !m.buf_full});
            check("model_overrun", {31'd0, overrun}, {31'd0, m.ovr});
        end
    end

    // Caller is at a negedge; load is sampled on the following rising edge.
    task automatic do_load(input logic [15:0] d);
        outr_data = d;
        outr_load = 1'b1;
        @(negedge clk);
        outr_load = 1'b0;
    endtask

    task automatic wait_fgo();
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (fgo) return;
        end
        timeout_fail("wait_fgo");
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (!busy) return;
            cnt++;
        end
        timeout_fail("wait_idle");
    endtask

    logic exp_a55a [20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int cnt;
        // Reset values.
        @(posedge clk);
        @(negedge clk);
        check("rst_tx",      {31'd0, tx},      32'd1);
        check("rst_fgo",     {31'd0, fgo},     32'd1);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // A55A from idle: literal waveform and latency.
        for (int k = 0; k < 20; k++)
            check("pin_a55a_model", {31'd0, frame_bit(16'hA55A, k)}, {31'd0, exp_a55a[k]});
        do_load(16'hA55A);
        check("a55a_fgo_at_e",  {31'd0, fgo},  32'd0);
        check("a55a_busy_at_e", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < N; c++) begin
                @(negedge clk);
                check("a55a_tx", {31'd0, tx}, {31'd0, exp_a55a[k]});
                if (k == 0 && c == 0) begin
                    check("a55a_busy_e1", {31'd0, busy}, 32'd1);
                    check("a55a_fgo_e1",  {31'd0, fgo},  32'd1);
                end
            end
        end
        @(negedge clk);
        check("a55a_busy_end", {31'd0, busy}, 32'd0);

        // 1234 then BEEF at first fgo=1: continuous 160-cycle busy window.
        do_load(16'h1234);
        wait_fgo();
        do_load(16'hBEEF);
        wait_idle(cnt);
        check("b2b_busy_len", cnt, 32'd158);
        check("b2b_overrun", {31'd0, overrun}, 32'd0);

        // 1111, 2222, then 3333 dropped with overrun.
        @(negedge clk);
        do_load(16'h1111);
        wait_fgo();
        do_load(16'h2222);
        do_load(16'h3333);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        wait_idle(cnt);
        check("ovr_busy_len", cnt, 32'd157);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset during DATA bit 5 of the low byte.
        @(negedge clk);
        do_load(16'h5A3C);
        repeat (26) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_tx",      {31'd0, tx},      32'd1);
        check("mid_rst_fgo",     {31'd0, fgo},     32'd1);
        check("mid_rst_busy",    {31'd0, busy},    32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_load(16'h00FF);
        check("post_rst_fgo", {31'd0, fgo}, 32'd0);
        wait_idle(cnt);
        check("post_rst_busy_len", cnt, 32'd80);

        // All-zero then all-one words.
        check("pin_ffff_start", {31'd0, frame_bit(16'hFFFF, 10)}, 32'd0);
        check("pin_0000_stop",  {31'd0, frame_bit(16'h0000, 19)}, 32'd1);
        @(negedge clk);
        do_load(16'h0000);
        wait_fgo();
        do_load(16'hFFFF);
        wait_idle(cnt);
        check("zf_busy_len", cnt, 32'd158);

        // Randomized loads at random spacing, including overruns.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 90)) @(negedge clk);
            do_load(16'($urandom));
        end
        wait_idle(cnt);
        repeat (4) @(negedge clk);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/outr_uart_tx.md
# outr_uart_tx

Serial output stage downstream of the CPU's OUTR register. It captures the 16-bit word when the CPU loads OUTR and transmits it on a single 8N1 UART line as two bytes, low byte first. It has a one-word holding buffer, so the CPU can queue the next word while the current one is shifting out. It exposes an FGO-style ready flag for the CPU's output-flag logic and a sticky overrun flag.

## Interface
- `Bits`, 16, width of the OUTR word; fixed at 16 (two bytes per word).
- `CLKS_PER_BIT`, 16, clock cycles per serial bit time; must be ≥ 2.

- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high; one clock domain, shared with the CPU.
- `outr_data`  in  16  word to send (the OUTR register value).
- `outr_load`  in  1  one-cycle strobe, asserted in the cycle the CPU loads OUTR.
- `fgo`  out  1  1 when the holding buffer is empty and a load will be accepted.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  1 while a frame is shifting (any state other than IDLE).
- `overrun`  out  1  sticky; set when a load arrives while `fgo`=0.

## Operation
- Reset values:
  - `tx`=1, `fgo`=1, `busy`=0, `overrun`=0.
  - FSM in IDLE; buffer empty; all counters 0.
- Load acceptance:
  - An `outr_load` with registered `fgo`=1 writes `outr_data` into the buffer and clears `fgo`.
  - An `outr_load` with `fgo`=0 is dropped and sets `overrun`. This holds even when the buffer is being drained on that same edge.
  - `overrun` clears only on reset.
- Buffer-to-shifter transfer:
  - Occurs when the FSM is in IDLE, or finishing STOP of the high byte, and the buffer is full.
  - The transfer copies the buffer into a 16-bit shifter, sets `fgo`=1, selects byte 0, and enters START.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. Leaves only on a transfer.
  - START: `tx`=0 for one bit time, then DATA.
  - DATA: 8 bits of the current byte, LSB first, one bit time each. A bit index 0..7 tracks position; after bit 7, go to STOP.
  - STOP: `tx`=1 for one bit time.
    - At the end of byte 0: go to START with byte 1 selected.
    - At the end of byte 1: transfer if the buffer is full, else go to IDLE.
- No idle gap between the two bytes of a word, or between back-to-back words.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide.
  - Its terminal count advances the FSM.
  - It resets to 0 on every state entry.

## Timing
- `outr_load` sampled at edge E, with `fgo`=1 and the FSM idle:
  - At E the buffer is full and `fgo`=0.
  - At E+1 the transfer occurs: `fgo`=1, `busy`=1, `tx`=0.
- Frame length: 20 × CLKS_PER_BIT cycles per word (2 × (1 start + 8 data + 1 stop)).
- `busy` falls on the edge that ends the high byte's STOP, unless a transfer occurs on that edge.
- `tx` and `busy` are registered outputs; no combinational path from inputs to outputs.
- Reset asserted mid-frame:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - The in-flight word and the buffered word are discarded.
  - The first load after reset deasserts behaves as from idle.

## Structure
- Shared package `outr_uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - `DATA_BITS`=8;
  - `BYTES_PER_WORD`=2.
- One sub-module, `bit_timer`:
  - Parameter CLKS_PER_BIT; inputs `clk`, `reset`, synchronous restart.
  - Output: one-cycle terminal-count pulse.
- The top level holds the buffer, shifter, FSM and flags.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset → `tx`=1, `fgo`=1, `busy`=0, `overrun`=0.
- Load 16'hA55A from idle → `tx` is 0, 0,1,0,1,1,0,1,0, 1, 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles. That is 80 cycles from E+1, after which `busy`=0.
- Load 16'h1234, then load 16'hBEEF at the first cycle `fgo`=1 → the 16'hBEEF start bit follows the 16'h1234 stop bit with no idle cycle, and `overrun` stays 0.
- Load 16'h1111, 16'h2222, then 16'h3333 while `fgo`=0 → `overrun`=1. 16'h1111 and 16'h2222 are sent; 16'h3333 never appears on `tx`.
- Reset pulse during DATA bit 5 of the low byte → `tx`=1 and `fgo`=1 before the next edge. A following load of 16'h00FF transmits correctly.
- Load 16'h0000, then 16'hFFFF → data bits are all 0, then all 1, and every start bit is 0 and every stop bit is 1.
